ncc_desc_load_ctrl: RTL and testbench

Sequences loading of a 16x16 NCC descriptor into the PE grid's descriptor registers. It accepts 32-bit words, each carrying four 8-bit pixels, over a valid/ready stream. It drives the packed pixels toward the four parallel log2 converters and generates the one-hot row-select and column-group-select strobes for each PE register load. It sits between the descriptor source (DMA/host FIFO) and the PE grid, and replaces the ad-hoc two-state load FSM.

---
 rtl/ncc_desc_load_ctrl_if.sv | 23 ++
 rtl/ncc_desc_load_ctrl.sv | 119 +++++++++++
 tb/tb_ncc_desc_load_ctrl.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ncc_desc_load_ctrl_if.sv
// rtl/ncc_desc_load_ctrl_if.sv - descriptor word stream in, PE register load bus out
interface ncc_desc_load_ctrl_if #(
    parameter int ROWS = 16,
    parameter int COLS = 16
);
    logic                in_valid;
    logic                in_ready;
    logic [31:0]         in_data;
    logic [31:0]         pix_data;
    logic [ROWS-1:0]     row_sel;
    logic [COLS/4-1:0]   colgrp_sel;
    logic                load_en;

    // master: descriptor source / PE-side observer; slave: the load controller
    modport master (
        output in_valid, in_data,
        input  in_ready, pix_data, row_sel, colgrp_sel, load_en
    );
    modport slave (
        input  in_valid, in_data,
        output in_ready, pix_data, row_sel, colgrp_sel, load_en
    );
endinterface

// File: rtl/ncc_desc_load_ctrl.sv
// rtl/ncc_desc_load_ctrl.sv - sequences 16x16 NCC descriptor words into PE registers
module ncc_desc_load_ctrl #(
    parameter int ROWS         = 16,
    parameter int COLS         = 16,
    parameter int PIX_PER_WORD = 4
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           i_start,
    input  logic                                           i_abort,
    ncc_desc_load_ctrl_if.slave                            bus,
    output logic [$clog2(ROWS*COLS/PIX_PER_WORD+1)-1:0]    o_word_count,
    output logic                                           o_busy,
    output logic                                           o_done
);
    localparam int NUM_WORDS = ROWS * COLS / PIX_PER_WORD;
    localparam int NGRP      = COLS / PIX_PER_WORD;
    localparam int WCW       = $clog2(NUM_WORDS + 1);
    localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int GW        = (NGRP > 1) ? $clog2(NGRP) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE
    } state_t;

    state_t            r_state;
    logic [31:0]       r_pix_data;
    logic [ROWS-1:0]   r_row_sel;
    logic [NGRP-1:0]   r_colgrp_sel;
    logic              r_load_en;
    logic              r_done;
    logic [WCW-1:0]    r_word_count;
    logic [RW-1:0]     r_row_cnt;
    logic [GW-1:0]     r_grp_cnt;

    logic              w_ready;
    logic              w_accept;
    logic              w_last;
    logic              w_grp_wrap;

    assign w_ready    = (r_state == ST_LOAD);
    // abort suppresses the accept even though in_ready is already high
    assign w_accept   = w_ready && bus.in_valid && !i_abort;
    assign w_last     = (r_word_count == WCW'(NUM_WORDS - 1));
    assign w_grp_wrap = (r_grp_cnt == GW'(NGRP - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_pix_data   <= '0;
            r_row_sel    <= '0;
            r_colgrp_sel <= '0;
            r_load_en    <= 1'b0;
            r_done       <= 1'b0;
            r_word_count <= '0;
            r_row_cnt    <= '0;
            r_grp_cnt    <= '0;
        end else if (i_abort) begin
            r_state      <= ST_IDLE;
            r_load_en    <= 1'b0;
            r_done       <= 1'b0;
            r_word_count <= '0;
            r_row_cnt    <= '0;
            r_grp_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_load_en <= 1'b0;
                    r_done    <= 1'b0;
                    if (i_start) begin
                        r_state      <= ST_LOAD;
                        r_word_count <= '0;
                        r_row_cnt    <= '0;
                        r_grp_cnt    <= '0;
                    end
                end
                ST_LOAD: begin
                    r_load_en <= w_accept;
                    if (w_accept) begin
                        r_pix_data   <= bus.in_data;
                        r_row_sel    <= ROWS'(1) << r_row_cnt;
                        r_colgrp_sel <= NGRP'(1) << r_grp_cnt;
                        r_word_count <= r_word_count + WCW'(1);
                        // column group runs fastest, carrying into the row
                        if (w_grp_wrap) begin
                            r_grp_cnt <= '0;
                            r_row_cnt <= r_row_cnt + RW'(1);
                        end else begin
                            r_grp_cnt <= r_grp_cnt + GW'(1);
                        end
                        if (w_last) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_load_en <= 1'b0;
                    r_done    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = w_ready;
    assign bus.pix_data   = r_pix_data;
    assign bus.row_sel    = r_row_sel;
    assign bus.colgrp_sel = r_colgrp_sel;
    assign bus.load_en    = r_load_en;
    assign o_word_count   = r_word_count;
    assign o_busy         = (r_state != ST_IDLE);
    assign o_done         = r_done;
endmodule

// File: tb/tb_ncc_desc_load_ctrl.sv
// tb/tb_ncc_desc_load_ctrl.sv - randomized bench for ncc_desc_load_ctrl with a word-level model
module tb_ncc_desc_load_ctrl;
    localparam int NWORDS = 64;
    localparam int NGRP   = 4;

    logic       clk;
    logic       rst;
    logic       i_start;
    logic       i_abort;
    logic [6:0] o_word_count;
    logic       o_busy;
    logic       o_done;

    int n_checks;
    int n_fail;

    ncc_desc_load_ctrl_if #(.ROWS(16), .COLS(16)) bus ();

    ncc_desc_load_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_abort      (i_abort),
        .bus          (bus),
        .o_word_count (o_word_count),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Descriptor-level model: loading flag, words taken so far, and what the PE bus should show.
    bit          m_loading;
    bit          m_done;
    bit          m_load_en;
    int          m_cnt;
    logic [31:0] m_pix;
    logic [15:0] m_row;
    logic [3:0]  m_grp;

    task automatic m_reset();
        m_loading = 0; m_done = 0; m_load_en = 0; m_cnt = 0;
        m_pix = '0; m_row = '0; m_grp = '0;
    endtask

    // Called at a falling edge: drive one cycle of inputs, predict, then compare after the next rising edge.
    task automatic step(input logic s, input logic a, input logic v, input logic [31:0] d);
        bit acc;
        bit was_done;
        i_start = s; i_abort = a; bus.in_valid = v; bus.in_data = d;
        #1;
        n_checks++;
        if (bus.in_ready !== m_loading) begin
            n_fail++;
            $display("FAIL in_ready got=%0b exp=%0b t=%0t", bus.in_ready, m_loading, $time);
        end
        acc = m_loading && v && !a;
        was_done = m_done;
        if (a) begin
            m_loading = 0; m_done = 0; m_load_en = 0; m_cnt = 0;
        end else if (m_loading) begin
            m_load_en = acc;
            if (acc) begin
                m_pix = d;
                m_row = 16'(1) << (m_cnt / NGRP);
                m_grp = 4'(1) << (m_cnt % NGRP);
                m_cnt++;
                if (m_cnt == NWORDS) begin
                    m_loading = 0;
                    m_done = 1;
                end
            end
        end else begin
            m_load_en = 0;
            m_done = 0;
            if (!was_done && s) begin
                m_loading = 1;
                m_cnt = 0;
            end
        end
        @(negedge clk);
        n_checks++;
        if (bus.load_en !== m_load_en || o_done !== m_done || o_busy !== (m_loading || m_done)
            || o_word_count !== 7'(m_cnt)) begin
            n_fail++;
            $display("FAIL ctrl got load_en=%0b done=%0b busy=%0b wc=%0d exp %0b %0b %0b %0d t=%0t",
                     bus.load_en, o_done, o_busy, o_word_count, m_load_en, m_done,
                     m_loading || m_done, m_cnt, $time);
        end
        n_checks++;
        if (bus.pix_data !== m_pix || bus.row_sel !== m_row || bus.colgrp_sel !== m_grp) begin
            n_fail++;
            $display("FAIL pe_bus got pix=%h row=%h grp=%h exp %h %h %h t=%0t",
                     bus.pix_data, bus.row_sel, bus.colgrp_sel, m_pix, m_row, m_grp, $time);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; i_start = 0; i_abort = 0; bus.in_valid = 0; bus.in_data = '0;
        m_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 0 || bus.load_en !== 0 || bus.pix_data !== 0 || bus.row_sel !== 0
            || bus.colgrp_sel !== 0 || o_word_count !== 0 || o_busy !== 0 || o_done !== 0) begin
            n_fail++;
            $display("FAIL reset_state got rdy=%0b le=%0b pix=%h row=%h grp=%h wc=%0d busy=%0b done=%0b exp all 0",
                     bus.in_ready, bus.load_en, bus.pix_data, bus.row_sel, bus.colgrp_sel,
                     o_word_count, o_busy, o_done);
        end
        rst = 1'b0;
        step(0, 0, 1, 32'hdead_beef);
    endtask

    // Continuous load with data=k; start re-asserted at words s1/s2 must change nothing.
    task automatic test_continuous(input int s1, input int s2);
        int steps;
        int pulses;
        int done_step;
        step(1, 0, 0, 0);
        steps = 1; pulses = 0; done_step = -1;
        for (int k = 0; k < NWORDS + 2; k++) begin
            step((k == s1 || k == s2) ? 1'b1 : 1'b0, 0, 1, 32'(k));
            steps++;
            if (bus.load_en === 1'b1) pulses++;
            if (o_done === 1'b1 && done_step < 0) done_step = steps;
            if (k == 0 || k == 5 || k == 63) begin
                n_checks++;
                if (bus.row_sel !== ((k == 0) ? 16'h0001 : (k == 5) ? 16'h0002 : 16'h8000)
                    || bus.colgrp_sel !== ((k == 0) ? 4'h1 : (k == 5) ? 4'h2 : 4'h8)
                    || bus.pix_data !== 32'(k)) begin
                    n_fail++;
                    $display("FAIL pulse%0d_sel got row=%h grp=%h pix=%h", k, bus.row_sel,
                             bus.colgrp_sel, bus.pix_data);
                end
            end
            if (k == 63) begin
                n_checks++;
                if (o_word_count !== 7'd64) begin
                    n_fail++;
                    $display("FAIL final_word_count got=%0d exp=64", o_word_count);
                end
            end
        end
        n_checks++;
        if (pulses != NWORDS || done_step != 65) begin
            n_fail++;
            $display("FAIL continuous_timing got pulses=%0d done_step=%0d exp 64 65", pulses, done_step);
        end
    endtask

    task automatic test_throttled();
        int pulses;
        int done_step;
        step(1, 0, 0, 0);
        pulses = 0; done_step = -1;
        for (int i = 0; i < 200; i++) begin
            step(0, 0, (i % 3 == 0) ? 1'b1 : 1'b0, $urandom);
            if (bus.load_en === 1'b1) pulses++;
            if (o_done === 1'b1 && done_step < 0) done_step = i + 2;
        end
        n_checks++;
        if (pulses != NWORDS || done_step != 191) begin
            n_fail++;
            $display("FAIL throttled got pulses=%0d done_step=%0d exp 64 191", pulses, done_step);
        end
    endtask

    task automatic test_abort();
        int dones;
        step(1, 0, 0, 0);
        for (int k = 0; k < 20; k++) step(0, 0, 1, $urandom);
        step(0, 1, 1, 32'h1234_5678);
        n_checks++;
        if (o_busy !== 0 || o_word_count !== 0 || bus.load_en !== 0 || bus.pix_data === 32'h1234_5678) begin
            n_fail++;
            $display("FAIL abort got busy=%0b wc=%0d le=%0b pix=%h exp 0 0 0 not-12345678",
                     o_busy, o_word_count, bus.load_en, bus.pix_data);
        end
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, $urandom);
            if (o_done === 1'b1) dones++;
        end
        n_checks++;
        if (dones != 0) begin
            n_fail++;
            $display("FAIL abort_no_done got=%0d exp=0", dones);
        end
        step(1, 0, 0, 0);
        step(0, 0, 1, $urandom);
        n_checks++;
        if (bus.row_sel !== 16'h0001 || bus.colgrp_sel !== 4'h1 || bus.load_en !== 1'b1) begin
            n_fail++;
            $display("FAIL reload_first got row=%h grp=%h le=%0b exp 0001 1 1",
                     bus.row_sel, bus.colgrp_sel, bus.load_en);
        end
        for (int k = 1; k < NWORDS; k++) step(0, 0, 1, $urandom);
        n_checks++;
        if (o_done !== 1'b1) begin
            n_fail++;
            $display("FAIL reload_done got=%0b exp=1", o_done);
        end
        step(0, 0, 0, 0);
    endtask

    task automatic test_async_reset();
        int loads;
        step(1, 0, 0, 0);
        for (int k = 0; k < 33; k++) step(0, 0, 1, $urandom | 32'h1);
        bus.in_valid = 1'b1; bus.in_data = 32'hffff_ffff;
        #3 rst = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 0 || bus.load_en !== 0 || bus.pix_data !== 0 || bus.row_sel !== 0
            || bus.colgrp_sel !== 0 || o_word_count !== 0 || o_busy !== 0 || o_done !== 0) begin
            n_fail++;
            $display("FAIL async_reset got rdy=%0b le=%0b pix=%h row=%h grp=%h wc=%0d busy=%0b exp all 0",
                     bus.in_ready, bus.load_en, bus.pix_data, bus.row_sel, bus.colgrp_sel,
                     o_word_count, o_busy);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_reset();
        loads = 0;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, $urandom);
            if (bus.load_en === 1'b1 || bus.in_ready === 1'b1) loads++;
        end
        n_checks++;
        if (loads != 0) begin
            n_fail++;
            $display("FAIL post_reset_idle got=%0d exp=0", loads);
        end
    endtask

    task automatic test_back_to_back();
        step(1, 0, 0, 0);
        for (int k = 0; k < NWORDS; k++) step(0, 0, 1, $urandom);
        n_checks++;
        if (o_done !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_done got=%0b exp=1", o_done);
        end
        step(1, 0, 1, $urandom);
        n_checks++;
        if (o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_start_in_done got busy=%0b exp=0", o_busy);
        end
        step(1, 0, 0, 0);
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_restart got in_ready=%0b exp=1", bus.in_ready);
        end
        for (int k = 0; k < NWORDS + 1; k++) step(0, 0, 1, $urandom);
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 1)), $urandom);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_continuous(-1, -1);
        test_throttled();
        test_abort();
        test_continuous(10, 40);
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
